// File: rtl/hbridge_pkg.sv
// hbridge_pkg
//   Shared definitions for the H-bridge coil model:
//   - bridge_state_t: 3-bit decoded bridge state encoding
//   - default current width, saturation magnitude and per-clock step sizes
package hbridge_pkg;

    typedef enum logic [2:0] {
        DRIVE_POS  = 3'd0,
        DRIVE_NEG  = 3'd1,
        SLOW_DECAY = 3'd2,
        FAST_DECAY = 3'd3,
        SHOOT      = 3'd4
    } bridge_state_t;

    localparam int DEF_CUR_W           = 13;
    localparam int DEF_MAX_CUR         = 4095;
    localparam int DEF_RISE_STEP       = 4;
    localparam int DEF_FAST_DECAY_STEP = 8;
    localparam int DEF_SLOW_DECAY_STEP = 1;

endpackage

// File: rtl/hbridge_state_decode.sv
// hbridge_state_decode
//   Purely combinational decode of the four gate drives into a bridge state.
//   Ports:
//     high_1, low_1           in   leg 1 high/low side gates
//     high_2, low_2           in   leg 2 high/low side gates
//     polarity_invert_config  in   1 = swap DRIVE_POS and DRIVE_NEG
//     state                   out  decoded state (hbridge_pkg encoding)
//   Build option: HBRIDGE_SHOOT_THROUGH_DETECT_EN -- when defined, a leg with
//   both switches on decodes as SHOOT; otherwise it decodes as SLOW_DECAY.
module hbridge_state_decode
    import hbridge_pkg::*;
(
    input  logic       high_1,
    input  logic       low_1,
    input  logic       high_2,
    input  logic       low_2,
    input  logic       polarity_invert_config,
    output logic [2:0] state
);

    bridge_state_t raw_state;
    bridge_state_t final_state;
    logic          shoot;

    assign shoot = (high_1 & low_1) | (high_2 & low_2);

    // Priority decode, highest first.
    always_comb begin
        raw_state = FAST_DECAY;
        if (shoot) begin
`ifdef HBRIDGE_SHOOT_THROUGH_DETECT_EN
            raw_state = SHOOT;
`else
            raw_state = SLOW_DECAY;
`endif
        end else if (high_1 & low_2 & ~high_2 & ~low_1) begin
            raw_state = DRIVE_POS;
        end else if (high_2 & low_1 & ~high_1 & ~low_2) begin
            raw_state = DRIVE_NEG;
        end else if ((low_1 & low_2) | (high_1 & high_2)) begin
            raw_state = SLOW_DECAY;
        end
    end

    // Polarity inversion acts after decode so the reported state is the
    // direction the current actually moves.
    always_comb begin
        final_state = raw_state;
        if (polarity_invert_config) begin
            if (raw_state == DRIVE_POS) begin
                final_state = DRIVE_NEG;
            end else if (raw_state == DRIVE_NEG) begin
                final_state = DRIVE_POS;
            end
        end
    end

    assign state = final_state;

endmodule

// File: rtl/hbridge_coil_model.sv
// hbridge_coil_model
//   Behavioural model of one H-bridge plus motor coil. Gates are sampled
//   each clock (no synchronizer), decoded combinationally, and a signed coil
//   current is integrated with one clock of latency.
//   Ports:
//     clock                   in   rising-edge clock
//     resetn                  in   synchronous, active-low reset
//     high_1, low_1           in   leg 1 gates
//     high_2, low_2           in   leg 2 gates
//     polarity_invert_config  in   1 = negate drive direction
//     current                 out  signed coil current (two's complement), registered
//     bridge_state            out  decoded state, registered (also the state debug view)
//     fault                   out  sticky shoot-through flag, registered
//   Build option: HBRIDGE_SHOOT_THROUGH_DETECT_EN -- when defined, shoot-through
//   zeroes the current and latches fault; otherwise fault is constant 0.
module hbridge_coil_model
    import hbridge_pkg::*;
#(
    parameter int CUR_W           = DEF_CUR_W,
    parameter int MAX_CUR         = DEF_MAX_CUR,
    parameter int RISE_STEP       = DEF_RISE_STEP,
    parameter int FAST_DECAY_STEP = DEF_FAST_DECAY_STEP,
    parameter int SLOW_DECAY_STEP = DEF_SLOW_DECAY_STEP
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             high_1,
    input  logic             low_1,
    input  logic             high_2,
    input  logic             low_2,
    input  logic             polarity_invert_config,
    output logic [CUR_W-1:0] current,
    output logic [2:0]       bridge_state,
    output logic             fault
);

    // One extra bit of headroom so step arithmetic never wraps before clamping.
    localparam logic signed [CUR_W:0] MAX_V  = (CUR_W+1)'(MAX_CUR);
    localparam logic signed [CUR_W:0] MIN_V  = -MAX_V;
    localparam logic signed [CUR_W:0] RISE_V = (CUR_W+1)'(RISE_STEP);
    localparam logic signed [CUR_W:0] FAST_V = (CUR_W+1)'(FAST_DECAY_STEP);
    localparam logic signed [CUR_W:0] SLOW_V = (CUR_W+1)'(SLOW_DECAY_STEP);

    logic [2:0]              dec_state;
    logic signed [CUR_W:0]   cur_ext;
    logic signed [CUR_W:0]   mag;
    logic signed [CUR_W:0]   step_sum;
    logic signed [CUR_W:0]   decay_step;
    logic signed [CUR_W:0]   next_ext;

    hbridge_state_decode u_decode (
        .high_1                 (high_1),
        .low_1                  (low_1),
        .high_2                 (high_2),
        .low_2                  (low_2),
        .polarity_invert_config (polarity_invert_config),
        .state                  (dec_state)
    );

    assign cur_ext = $signed({current[CUR_W-1], current});
    assign mag     = cur_ext[CUR_W] ? -cur_ext : cur_ext;

    always_comb begin
        next_ext   = cur_ext;
        step_sum   = '0;
        decay_step = FAST_V;
        case (dec_state)
            DRIVE_POS: begin
                step_sum = cur_ext + RISE_V;
                next_ext = (step_sum > MAX_V) ? MAX_V : step_sum;
            end
            DRIVE_NEG: begin
                step_sum = cur_ext - RISE_V;
                next_ext = (step_sum < MIN_V) ? MIN_V : step_sum;
            end
            SLOW_DECAY, FAST_DECAY: begin
                decay_step = (dec_state == SLOW_DECAY) ? SLOW_V : FAST_V;
                // Snap to exactly zero when within one step so the decay never
                // crosses zero or flips sign.
                if (mag <= decay_step) begin
                    next_ext = '0;
                end else if (cur_ext[CUR_W]) begin
                    next_ext = cur_ext + decay_step;
                end else begin
                    next_ext = cur_ext - decay_step;
                end
            end
            default: begin
                // SHOOT: only reachable with shoot-through detection built in.
                next_ext = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            current      <= '0;
            bridge_state <= FAST_DECAY;
            fault        <= 1'b0;
        end else begin
            current      <= next_ext[CUR_W-1:0];
            bridge_state <= dec_state;
`ifdef HBRIDGE_SHOOT_THROUGH_DETECT_EN
            if (dec_state == SHOOT) begin
                fault <= 1'b1;
            end
`else
            fault        <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_hbridge_coil_model.sv
// tb_hbridge_coil_model
//   Directed-vector bench for hbridge_coil_model. The driver applies one gate
//   pattern per clock (at the falling edge) and pushes the hand-computed
//   expected {current, bridge_state, fault} into exp_q; the monitor pops one
//   entry just after each rising edge and compares it to the DUT outputs.
module tb_hbridge_coil_model;

    localparam int CUR_W = 13;
    localparam int W     = CUR_W + 3 + 1;

    logic             clock;
    logic             resetn;
    logic             high_1, low_1, high_2, low_2;
    logic             polarity_invert_config;
    logic [CUR_W-1:0] current;
    logic [2:0]       bridge_state;
    logic             fault;

    logic [W-1:0] exp_q[$];
    int total;
    int bad;
    int pops;

    hbridge_coil_model dut (
        .clock                  (clock),
        .resetn                 (resetn),
        .high_1                 (high_1),
        .low_1                  (low_1),
        .high_2                 (high_2),
        .low_2                  (low_2),
        .polarity_invert_config (polarity_invert_config),
        .current                (current),
        .bridge_state           (bridge_state),
        .fault                  (fault)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- driver tasks ----------------
    // One clock: apply gates, expect the registered result after the next edge.
    task automatic step(input logic rn, input logic [3:0] gates, input logic inv,
                        input int exp_cur, input int exp_st, input logic exp_f);
        @(negedge clock);
        resetn                 = rn;
        {high_1, low_1, high_2, low_2} = gates;
        polarity_invert_config = inv;
        exp_q.push_back({CUR_W'(exp_cur), 3'(exp_st), exp_f});
    endtask

    // Gate patterns as {high_1, low_1, high_2, low_2}.
    localparam logic [3:0] G_POS   = 4'b1001;
    localparam logic [3:0] G_NEG   = 4'b0110;
    localparam logic [3:0] G_OFF   = 4'b0000;
    localparam logic [3:0] G_LOWS  = 4'b0101;
    localparam logic [3:0] G_HIGHS = 4'b1010;
    localparam logic [3:0] G_SHT1  = 4'b1100;
    localparam logic [3:0] G_H1    = 4'b1000;
    localparam logic [3:0] G_L2    = 4'b0001;

    task automatic do_reset();
        // Gates left in drive to show reset wins over a live drive request.
        step(1'b0, G_POS, 1'b0, 0, 3, 1'b0);
        step(1'b0, G_POS, 1'b0, 0, 3, 1'b0);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                pops++;
                total++;
                if (current !== e[W-1:4]) begin
                    bad++;
                    $display("FAIL current vec=%0d got=%0d want=%0d", pops,
                             $signed(current), $signed(e[W-1:4]));
                end
                total++;
                if (bridge_state !== e[3:1]) begin
                    bad++;
                    $display("FAIL bridge_state vec=%0d got=%0d want=%0d", pops,
                             bridge_state, e[3:1]);
                end
                total++;
                if (fault !== e[0]) begin
                    bad++;
                    $display("FAIL fault vec=%0d got=%0b want=%0b", pops, fault, e[0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        total = 0;
        bad   = 0;
        pops  = 0;
        resetn = 1'b0;
        {high_1, low_1, high_2, low_2} = 4'b0000;
        polarity_invert_config = 1'b0;

        do_reset();

        // Drive positive 10 clocks: 4..40.
        for (int i = 1; i <= 10; i++) step(1'b1, G_POS, 1'b0, 4 * i, 0, 1'b0);
        // All off: fast decay 32,24,16,8,0 then holds at 0.
        for (int i = 1; i <= 7; i++) step(1'b1, G_OFF, 1'b0, (i <= 5) ? 40 - 8 * i : 0, 3, 1'b0);

        // Saturation: climb from 0, clamp at +4095 (reached on clock 1024).
        for (int i = 1; i <= 1100; i++)
            step(1'b1, G_POS, 1'b0, (4 * i > 4095) ? 4095 : 4 * i, 0, 1'b0);
        // Reverse: 4091, 4087, ... clamps at -4095 on clock 2048.
        for (int k = 1; k <= 2100; k++)
            step(1'b1, G_NEG, 1'b0, (4095 - 4 * k < -4095) ? -4095 : 4095 - 4 * k, 1, 1'b0);

        do_reset();
        // Slow decay with both lows: 20 -> 19..0, then hold.
        for (int i = 1; i <= 5; i++) step(1'b1, G_POS, 1'b0, 4 * i, 0, 1'b0);
        for (int i = 1; i <= 22; i++) step(1'b1, G_LOWS, 1'b0, (i <= 20) ? 20 - i : 0, 2, 1'b0);
        // Slow decay with both highs.
        for (int i = 1; i <= 5; i++) step(1'b1, G_POS, 1'b0, 4 * i, 0, 1'b0);
        for (int i = 1; i <= 21; i++) step(1'b1, G_HIGHS, 1'b0, (i <= 20) ? 20 - i : 0, 2, 1'b0);

        // Negative side decay: -12 -> -4 -> 0 (snap when |current| <= step).
        for (int i = 1; i <= 3; i++) step(1'b1, G_NEG, 1'b0, -4 * i, 1, 1'b0);
        step(1'b1, G_OFF, 1'b0, -4, 3, 1'b0);
        step(1'b1, G_OFF, 1'b0, 0, 3, 1'b0);
        // Slow decay on negative current moves up toward zero.
        step(1'b1, G_NEG, 1'b0, -4, 1, 1'b0);
        step(1'b1, G_LOWS, 1'b0, -3, 2, 1'b0);

        // Polarity inversion: high_1/low_2 now drives negative.
        do_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, G_POS, 1'b1, -4 * i, 1, 1'b0);
        step(1'b1, G_NEG, 1'b1, -16, 0, 1'b0);

        // Single switch on decodes as fast decay.
        do_reset();
        for (int i = 1; i <= 3; i++) step(1'b1, G_POS, 1'b0, 4 * i, 0, 1'b0);
        step(1'b1, G_H1, 1'b0, 4, 3, 1'b0);
        step(1'b1, G_L2, 1'b0, 0, 3, 1'b0);

        // Shoot-through at current 40.
        do_reset();
        for (int i = 1; i <= 10; i++) step(1'b1, G_POS, 1'b0, 4 * i, 0, 1'b0);
`ifdef HBRIDGE_SHOOT_THROUGH_DETECT_EN
        step(1'b1, G_SHT1, 1'b0, 0, 4, 1'b1);
        for (int i = 1; i <= 3; i++) step(1'b1, G_POS, 1'b0, 4 * i, 0, 1'b1);
        step(1'b1, G_OFF, 1'b0, 4, 3, 1'b1);
        step(1'b0, G_POS, 1'b0, 0, 3, 1'b0);
        step(1'b1, G_POS, 1'b0, 4, 0, 1'b0);
`else
        step(1'b1, G_SHT1, 1'b0, 39, 2, 1'b0);
        for (int i = 1; i <= 3; i++) step(1'b1, G_POS, 1'b0, 39 + 4 * i, 0, 1'b0);
        step(1'b1, G_OFF, 1'b0, 43, 3, 1'b0);
`endif

        // Let the monitor drain the queue, bounded.
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) @(posedge clock);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
